// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: opcodes, functs,
// ALU/memory operation codes, FSM states and instruction classes.
package multicycle_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      MEM_WORD = 2'd0,
      MEM_HALF = 2'd1,
      MEM_BYTE = 2'd2
   } mem_op_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CLS_R_ALU     = 4'd0,
      CLS_SHIFT_IMM = 4'd1,
      CLS_I_ALU     = 4'd2,
      CLS_LUI       = 4'd3,
      CLS_LOAD      = 4'd4,
      CLS_STORE     = 4'd5,
      CLS_BEQ       = 4'd6,
      CLS_BNE       = 4'd7,
      CLS_J         = 4'd8,
      CLS_JAL       = 4'd9,
      CLS_JR        = 4'd10,
      CLS_JALR      = 4'd11,
      CLS_ILLEGAL   = 4'd12
   } insn_class_e;

   typedef struct packed {
      insn_class_e cls;
      alu_op_e     alu_op;
      mem_op_e     mem_op;
      logic        mem_ext;
   } decode_t;

   function automatic decode_t mk_dec(insn_class_e c, alu_op_e a, mem_op_e m, logic e);
      decode_t d;
      d.cls     = c;
      d.alu_op  = a;
      d.mem_op  = m;
      d.mem_ext = e;
      return d;
   endfunction

   function automatic logic uses_imm(insn_class_e c);
      return (c == CLS_I_ALU) || (c == CLS_LUI) || (c == CLS_LOAD) || (c == CLS_STORE);
   endfunction

endpackage

// File: rtl/insn_class_decode.sv
// Combinational OpCode/funct classifier: instruction class plus the ALU and
// memory controls that class will need in later states.
module insn_class_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   output decode_t    dec
);

   always_comb begin
      dec = mk_dec(CLS_ILLEGAL, ALU_ADD, MEM_WORD, 1'b0);
      case (OpCode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_ADDU: dec = mk_dec(CLS_R_ALU, ALU_ADD, MEM_WORD, 1'b0);
               FN_SUB, FN_SUBU: dec = mk_dec(CLS_R_ALU, ALU_SUB, MEM_WORD, 1'b0);
               FN_AND:          dec = mk_dec(CLS_R_ALU, ALU_AND, MEM_WORD, 1'b0);
               FN_OR:           dec = mk_dec(CLS_R_ALU, ALU_OR, MEM_WORD, 1'b0);
               FN_XOR:          dec = mk_dec(CLS_R_ALU, ALU_XOR, MEM_WORD, 1'b0);
               FN_NOR:          dec = mk_dec(CLS_R_ALU, ALU_NOR, MEM_WORD, 1'b0);
               FN_SLT:          dec = mk_dec(CLS_R_ALU, ALU_SLT, MEM_WORD, 1'b0);
               FN_SLTU:         dec = mk_dec(CLS_R_ALU, ALU_SLTU, MEM_WORD, 1'b0);
               FN_SLL:          dec = mk_dec(CLS_SHIFT_IMM, ALU_SLL, MEM_WORD, 1'b0);
               FN_SRL:          dec = mk_dec(CLS_SHIFT_IMM, ALU_SRL, MEM_WORD, 1'b0);
               FN_SRA:          dec = mk_dec(CLS_SHIFT_IMM, ALU_SRA, MEM_WORD, 1'b0);
               FN_JR:           dec = mk_dec(CLS_JR, ALU_ADD, MEM_WORD, 1'b0);
               FN_JALR:         dec = mk_dec(CLS_JALR, ALU_ADD, MEM_WORD, 1'b0);
               default: ;
            endcase
         end
         OP_J:              dec = mk_dec(CLS_J, ALU_ADD, MEM_WORD, 1'b0);
         OP_JAL:            dec = mk_dec(CLS_JAL, ALU_ADD, MEM_WORD, 1'b0);
         OP_BEQ:            dec = mk_dec(CLS_BEQ, ALU_SUB, MEM_WORD, 1'b0);
         OP_BNE:            dec = mk_dec(CLS_BNE, ALU_SUB, MEM_WORD, 1'b0);
         OP_ADDI, OP_ADDIU: dec = mk_dec(CLS_I_ALU, ALU_ADD, MEM_WORD, 1'b0);
         OP_SLTI:           dec = mk_dec(CLS_I_ALU, ALU_SLT, MEM_WORD, 1'b0);
         OP_SLTIU:          dec = mk_dec(CLS_I_ALU, ALU_SLTU, MEM_WORD, 1'b0);
         OP_ANDI:           dec = mk_dec(CLS_I_ALU, ALU_AND, MEM_WORD, 1'b0);
         OP_ORI:            dec = mk_dec(CLS_I_ALU, ALU_OR, MEM_WORD, 1'b0);
         OP_XORI:           dec = mk_dec(CLS_I_ALU, ALU_XOR, MEM_WORD, 1'b0);
         OP_LUI:            dec = mk_dec(CLS_LUI, ALU_LUI, MEM_WORD, 1'b0);
         OP_LB:             dec = mk_dec(CLS_LOAD, ALU_ADD, MEM_BYTE, 1'b1);
         OP_LH:             dec = mk_dec(CLS_LOAD, ALU_ADD, MEM_HALF, 1'b1);
         OP_LW:             dec = mk_dec(CLS_LOAD, ALU_ADD, MEM_WORD, 1'b1);
         OP_LBU:            dec = mk_dec(CLS_LOAD, ALU_ADD, MEM_BYTE, 1'b0);
         OP_LHU:            dec = mk_dec(CLS_LOAD, ALU_ADD, MEM_HALF, 1'b0);
         OP_SB:             dec = mk_dec(CLS_STORE, ALU_ADD, MEM_BYTE, 1'b0);
         OP_SH:             dec = mk_dec(CLS_STORE, ALU_ADD, MEM_HALF, 1'b0);
         OP_SW:             dec = mk_dec(CLS_STORE, ALU_ADD, MEM_WORD, 1'b0);
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing, memory
// wait counter with timeout, and per-state datapath control decode.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] RegSrc,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [3:0] ALUOp,
   output logic       MemReq,
   output logic       MemWrite,
   output logic [1:0] MemOp,
   output logic       MemExt,
   output logic       InstrDone,
   output logic       Fault,
   output logic [2:0] State
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   state_e         state_q, state_d;
   decode_t        dec_q, dec_d;
   decode_t        dec_now;
   logic [CW-1:0]  wait_q, wait_d;
   logic           fault_q, fault_d;
   logic           mem_timeout;
   logic           br_taken;

   insn_class_decode u_decode (
      .OpCode (OpCode),
      .funct  (funct),
      .dec    (dec_now)
   );

   assign mem_timeout = (state_q == ST_MEM) && !mem_ready &&
                        (wait_q == CW'(MEM_TIMEOUT - 1));
   assign br_taken    = (dec_q.cls == CLS_BEQ) ? Zero : !Zero;

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      wait_d  = wait_q;
      fault_d = fault_q;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            dec_d = dec_now;
            case (dec_now.cls)
               CLS_J, CLS_JAL, CLS_JR, CLS_JALR: state_d = ST_FETCH;
               CLS_ILLEGAL: begin
                  state_d = ST_HALT;
                  fault_d = 1'b1;
               end
               default: state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (dec_q.cls)
               CLS_BEQ, CLS_BNE: state_d = ST_FETCH;
               CLS_LOAD, CLS_STORE: begin
                  state_d = ST_MEM;
                  wait_d  = '0;
               end
               default: state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_d = (dec_q.cls == CLS_STORE) ? ST_FETCH : ST_WB;
            end else if (mem_timeout) begin
               state_d = ST_HALT;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         ST_WB:   state_d = ST_FETCH;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         dec_q   <= mk_dec(CLS_ILLEGAL, ALU_ADD, MEM_WORD, 1'b0);
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   // Outputs decode the registered state and are forced low while rst is high,
   // so a reset landing mid-MEM drops MemReq without waiting for a clock.
   always_comb begin
      PCWrite   = 1'b0;
      PCSrc     = 2'd0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      RegDst    = 2'd0;
      RegSrc    = 2'd0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      MemOp     = MEM_WORD;
      MemExt    = 1'b0;
      InstrDone = 1'b0;
      Fault     = fault_q;
      if (!rst) begin
         if (state_q == ST_EXEC || state_q == ST_MEM) begin
            ALUOp   = dec_q.alu_op;
            ALUSrcA = (dec_q.cls == CLS_SHIFT_IMM);
            ALUSrcB = uses_imm(dec_q.cls);
         end
         case (state_q)
            ST_FETCH: begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               PCSrc   = 2'd0;
            end
            ST_DECODE: begin
               case (dec_now.cls)
                  CLS_J, CLS_JAL: begin
                     PCWrite   = 1'b1;
                     PCSrc     = 2'd2;
                     InstrDone = 1'b1;
                  end
                  CLS_JR, CLS_JALR: begin
                     PCWrite   = 1'b1;
                     PCSrc     = 2'd3;
                     InstrDone = 1'b1;
                  end
                  CLS_ILLEGAL: Fault = 1'b1;
                  default: ;
               endcase
               if (dec_now.cls == CLS_JAL || dec_now.cls == CLS_JALR) begin
                  RegWrite = 1'b1;
                  RegSrc   = 2'd2;
                  RegDst   = (dec_now.cls == CLS_JAL) ? 2'd2 : 2'd1;
               end
            end
            ST_EXEC: begin
               if (dec_q.cls == CLS_BEQ || dec_q.cls == CLS_BNE) begin
                  PCWrite   = br_taken;
                  PCSrc     = br_taken ? 2'd1 : 2'd0;
                  InstrDone = 1'b1;
               end
            end
            ST_MEM: begin
               MemReq    = 1'b1;
               MemWrite  = (dec_q.cls == CLS_STORE);
               MemOp     = dec_q.mem_op;
               MemExt    = dec_q.mem_ext;
               InstrDone = mem_ready && (dec_q.cls == CLS_STORE);
               if (mem_timeout) Fault = 1'b1;
            end
            ST_WB: begin
               RegWrite  = 1'b1;
               RegSrc    = (dec_q.cls == CLS_LOAD) ? 2'd1 : 2'd0;
               RegDst    = (dec_q.cls == CLS_R_ALU || dec_q.cls == CLS_SHIFT_IMM) ? 2'd1 : 2'd0;
               InstrDone = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instructions with expected
// retire behaviour, plus timeout, illegal-opcode and mid-MEM reset sequences.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] OpCode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB;
   logic       MemReq, MemWrite, MemExt, InstrDone, Fault;
   logic [1:0] PCSrc, RegDst, RegSrc, MemOp;
   logic [3:0] ALUOp;
   logic [2:0] State;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .OpCode    (OpCode),
      .funct     (funct),
      .Zero      (Zero),
      .mem_ready (mem_ready),
      .PCWrite   (PCWrite),
      .PCSrc     (PCSrc),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .RegDst    (RegDst),
      .RegSrc    (RegSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .MemReq    (MemReq),
      .MemWrite  (MemWrite),
      .MemOp     (MemOp),
      .MemExt    (MemExt),
      .InstrDone (InstrDone),
      .Fault     (Fault),
      .State     (State)
   );

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       zero;
      int         delay;
      int         lat;
      logic       pcw;
      logic [1:0] pcsrc;
      logic       rw;
      logic [1:0] rdst;
      logic [1:0] rsrc;
      int         memc;
      logic       mw;
      logic       mext;
      logic       chk_alu;
      logic [3:0] aluop;
      logic       srca;
      logic       srcb;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      OpCode = 6'h00;
      funct = 6'h00;
      Zero = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      check("rst/State", 32'(State), 32'd0);
      check("rst/IRWrite", 32'(IRWrite), 32'd0);
      check("rst/PCWrite", 32'(PCWrite), 32'd0);
      check("rst/RegWrite", 32'(RegWrite), 32'd0);
      check("rst/MemReq", 32'(MemReq), 32'd0);
      check("rst/InstrDone", 32'(InstrDone), 32'd0);
      check("rst/Fault", 32'(Fault), 32'd0);
      rst = 1'b0;
   endtask

   // Entry: just after a negedge with the DUT in FETCH.
   task automatic run_insn(input vec_t v);
      vec_t e;
      int   memseen = 0;
      bit   done = 1'b0;
      check({v.name, "/start_state"}, 32'(State), 32'd0);
      sb.push_back(v);
      OpCode = v.op;
      funct  = v.fn;
      Zero   = v.zero;
      for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
         mem_ready = (State == 3'd3) && (memseen == v.delay);
         #1;
         if (cyc == 1) begin
            check({v.name, "/fetch_IRWrite"}, 32'(IRWrite), 32'd1);
            check({v.name, "/fetch_PCWrite"}, 32'(PCWrite), 32'd1);
            check({v.name, "/fetch_PCSrc"}, 32'(PCSrc), 32'd0);
         end
         if (State == 3'd2 && v.chk_alu) begin
            check({v.name, "/ALUOp"}, 32'(ALUOp), 32'(v.aluop));
            check({v.name, "/ALUSrcA"}, 32'(ALUSrcA), 32'(v.srca));
            check({v.name, "/ALUSrcB"}, 32'(ALUSrcB), 32'(v.srcb));
         end
         if (MemReq) begin
            memseen++;
            check({v.name, "/MemWrite"}, 32'(MemWrite), 32'(v.mw));
            check({v.name, "/MemExt"}, 32'(MemExt), 32'(v.mext));
         end
         if (InstrDone) begin
            e = sb.pop_front();
            check({e.name, "/latency"}, 32'(cyc), 32'(e.lat));
            check({e.name, "/PCWrite"}, 32'(PCWrite), 32'(e.pcw));
            check({e.name, "/PCSrc"}, 32'(PCSrc), 32'(e.pcsrc));
            check({e.name, "/RegWrite"}, 32'(RegWrite), 32'(e.rw));
            check({e.name, "/RegDst"}, 32'(RegDst), 32'(e.rdst));
            check({e.name, "/RegSrc"}, 32'(RegSrc), 32'(e.rsrc));
            check({e.name, "/mem_cycles"}, 32'(memseen), 32'(e.memc));
            done = 1'b1;
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s/retire_timeout: got no InstrDone expected one within 40 cycles", v.name);
         if (sb.size() > 0) void'(sb.pop_front());
      end
   endtask

   initial begin
      int  memseen;
      bit  halted;

      //                 name    op     fn     z  dly lat pcw src rw dst rsrc mc mw mx alu op srca srcb
      vecs.push_back(vec_t'{"add",  6'h00, 6'h20, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0,  0, 0});
      vecs.push_back(vec_t'{"sll",  6'h00, 6'h00, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 1, 8,  1, 0});
      vecs.push_back(vec_t'{"sra",  6'h00, 6'h03, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 1, 10, 1, 0});
      vecs.push_back(vec_t'{"addi", 6'h08, 6'h00, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0,  0, 1});
      vecs.push_back(vec_t'{"lui",  6'h0F, 6'h00, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 11, 0, 1});
      vecs.push_back(vec_t'{"lw3",  6'h23, 6'h00, 0, 3, 8, 0, 0, 1, 0, 1, 4, 0, 1, 1, 0,  0, 1});
      vecs.push_back(vec_t'{"lbu0", 6'h24, 6'h00, 0, 0, 5, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0,  0, 1});
      vecs.push_back(vec_t'{"sw2",  6'h2B, 6'h00, 0, 2, 6, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0,  0, 1});
      vecs.push_back(vec_t'{"sw0",  6'h2B, 6'h00, 0, 0, 4, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0,  0, 1});
      vecs.push_back(vec_t'{"beqT", 6'h04, 6'h00, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0});
      vecs.push_back(vec_t'{"beqN", 6'h04, 6'h00, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0});
      vecs.push_back(vec_t'{"bneT", 6'h05, 6'h00, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0});
      vecs.push_back(vec_t'{"bneN", 6'h05, 6'h00, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0});
      vecs.push_back(vec_t'{"j",    6'h02, 6'h00, 0, 0, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0});
      vecs.push_back(vec_t'{"jal",  6'h03, 6'h00, 0, 0, 2, 1, 2, 1, 2, 2, 0, 0, 0, 0, 0,  0, 0});
      vecs.push_back(vec_t'{"jr",   6'h00, 6'h08, 0, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0});
      vecs.push_back(vec_t'{"jalr", 6'h00, 6'h09, 0, 0, 2, 1, 3, 1, 1, 2, 0, 0, 0, 0, 0,  0, 0});

      do_reset();
      foreach (vecs[i]) run_insn(vecs[i]);

      // Store that never sees mem_ready must time out after 16 MEM cycles.
      do_reset();
      OpCode  = 6'h2B;
      memseen = 0;
      halted  = 1'b0;
      for (int c = 0; c < 40 && !halted; c++) begin
         mem_ready = 1'b0;
         #1;
         if (MemReq) memseen++;
         if (State == 3'd5) halted = 1'b1;
         else @(negedge clk);
      end
      check("tmo/halted", 32'(halted), 32'd1);
      check("tmo/MemReq_cycles", 32'(memseen), 32'd16);
      check("tmo/Fault", 32'(Fault), 32'd1);
      check("tmo/MemReq", 32'(MemReq), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check("halt/State", 32'(State), 32'd5);
         check("halt/enables", 32'({PCWrite, IRWrite, RegWrite, MemReq, InstrDone}), 32'd0);
         check("halt/Fault", 32'(Fault), 32'd1);
      end

      // Illegal opcode faults in DECODE with no write enables.
      do_reset();
      OpCode = 6'h3F;
      @(negedge clk);
      #1;
      check("ill/State", 32'(State), 32'd1);
      check("ill/Fault", 32'(Fault), 32'd1);
      check("ill/enables", 32'({PCWrite, IRWrite, RegWrite, MemReq, InstrDone}), 32'd0);
      @(negedge clk);
      #1;
      check("ill/halt_State", 32'(State), 32'd5);
      check("ill/halt_Fault", 32'(Fault), 32'd1);

      // Reset asserted mid-MEM drops MemReq without a clock edge.
      do_reset();
      OpCode = 6'h23;
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("mrst/in_MEM", 32'(State), 32'd3);
      check("mrst/MemReq_before", 32'(MemReq), 32'd1);
      rst = 1'b1;
      #1;
      check("mrst/MemReq_now", 32'(MemReq), 32'd0);
      check("mrst/State_now", 32'(State), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mrst/State_after", 32'(State), 32'd0);
      check("mrst/Fault_after", 32'(Fault), 32'd0);
      check("mrst/IRWrite_after", 32'(IRWrite), 32'd1);
      @(negedge clk);
      #1;
      check("mrst/decode_next", 32'(State), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
